// File: rtl/ttl_mux_scan_pkg.sv
// Shared constants for the scanned multiplexer: select-source modes and scan directions.
package ttl_mux_scan_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  typedef enum logic {
    SCAN_DIR_UP   = 1'b0,
    SCAN_DIR_DOWN = 1'b1
  } scan_dir_e;

endpackage

// File: rtl/ttl_mux_scan_counter.sv
// Modulo-MODULUS up/down scan counter with saturating load and a one-cycle wrap pulse.
module ttl_mux_scan_counter
  import ttl_mux_scan_pkg::*;
#(
  parameter int MODULUS      = 4,
  parameter int WIDTH_SELECT = $clog2(MODULUS)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Load,
  input  logic [WIDTH_SELECT-1:0] Load_value,
  input  logic                    Step,
  input  logic                    Dir,
  output logic [WIDTH_SELECT-1:0] Count,
  output logic                    Wrap
);

  localparam logic [WIDTH_SELECT-1:0] LAST = WIDTH_SELECT'(MODULUS - 1);

  // Load values past the last input clamp to it, so the counter never leaves range.
  function automatic logic [WIDTH_SELECT-1:0] sat_load(input logic [WIDTH_SELECT-1:0] v);
    return (v > LAST) ? LAST : v;
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Count <= '0;
      Wrap  <= 1'b0;
    end else if (Load) begin
      Count <= sat_load(Load_value);
      Wrap  <= 1'b0;
    end else if (Step) begin
      if (Dir == SCAN_DIR_DOWN) begin
        if (Count == '0) begin
          Count <= LAST;
          Wrap  <= 1'b1;
        end else begin
          Count <= Count - 1'b1;
          Wrap  <= 1'b0;
        end
      end else begin
        if (Count == LAST) begin
          Count <= '0;
          Wrap  <= 1'b1;
        end else begin
          Count <= Count + 1'b1;
          Wrap  <= 1'b0;
        end
      end
    end else begin
      Wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/ttl_mux_scan.sv
// Multi-block N-input multiplexer with registered outputs; select comes from the
// Select port or from the internal scan counter.
module ttl_mux_scan
  import ttl_mux_scan_pkg::*;
#(
  parameter int BLOCKS       = 2,
  parameter int WIDTH_IN     = 4,
  parameter int WIDTH_SELECT = $clog2(WIDTH_IN)
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [BLOCKS-1:0]            Enable_bar,
  input  logic                         Mode,
  input  logic [WIDTH_SELECT-1:0]      Select,
  input  logic                         Load,
  input  logic [WIDTH_SELECT-1:0]      Load_value,
  input  logic                         Step,
  input  logic                         Dir,
  input  logic [BLOCKS*WIDTH_IN-1:0]   A_2D,
  output logic [BLOCKS-1:0]            Y,
  output logic [WIDTH_SELECT-1:0]      Y_select,
  output logic                         Wrap
);

  logic [WIDTH_IN-1:0]     a_arr [BLOCKS];
  logic [WIDTH_SELECT-1:0] cnt;
  logic [WIDTH_SELECT-1:0] sel_eff;
  logic [BLOCKS-1:0]       y_next;

  for (genvar b = 0; b < BLOCKS; b++) begin : g_unpack
    assign a_arr[b] = A_2D[b*WIDTH_IN +: WIDTH_IN];
  end

  ttl_mux_scan_counter #(
    .MODULUS      (WIDTH_IN),
    .WIDTH_SELECT (WIDTH_SELECT)
  ) u_counter (
    .Clk        (Clk),
    .Reset      (Reset),
    .Load       (Load),
    .Load_value (Load_value),
    .Step       (Step),
    .Dir        (Dir),
    .Count      (cnt),
    .Wrap       (Wrap)
  );

  // Selects past the last input (non-power-of-two widths) yield 0 instead of X.
  function automatic logic pick(input logic [WIDTH_IN-1:0] row,
                                input logic [WIDTH_SELECT-1:0] s);
    logic r;
    r = 1'b0;
    for (int i = 0; i < WIDTH_IN; i++) begin
      if (s == WIDTH_SELECT'(i)) r = row[i];
    end
    return r;
  endfunction

  assign sel_eff = (Mode == MODE_SCAN) ? cnt : Select;

  always_comb begin
    y_next = '0;
    for (int b = 0; b < BLOCKS; b++) begin
      if (!Enable_bar[b]) y_next[b] = pick(a_arr[b], sel_eff);
    end
  end

  // Output register: shares its edge with the counter, so Y_select names the muxed input.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Y        <= '0;
      Y_select <= '0;
    end else begin
      Y        <= y_next;
      Y_select <= sel_eff;
    end
  end

endmodule
